// File: rtl/cart_load_ctrl_if.sv
// Bus bundle between the ROM downloader and the cart memory.
//   ioctl_download : download in progress (HPS side)
//   ioctl_wr       : one-cycle byte strobe
//   ioctl_addr     : byte address of the strobe
//   ioctl_dout     : byte data of the strobe
//   mem_addr       : cart memory address
//   mem_wdata      : cart memory write data
//   mem_we         : cart memory write enable
//   mem_rdata      : cart memory read data, valid one cycle after mem_addr
// master = HPS + memory side, slave = load controller.
interface cart_load_ctrl_if #(
   parameter int AW = 13
);
   logic          ioctl_download;
   logic          ioctl_wr;
   logic [24:0]   ioctl_addr;
   logic [7:0]    ioctl_dout;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          mem_we;
   logic [7:0]    mem_rdata;

   modport master (
      output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, mem_rdata,
      input  mem_addr, mem_wdata, mem_we
   );

   modport slave (
      input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, mem_rdata,
      output mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/cart_load_ctrl.sv
// Cart ROM load controller.
// Writes the HPS byte stream into cart memory, then pads the image up to a
// power-of-two span (minimum 4 KiB, at most 2^AW) by copying it onto itself,
// and keeps the core in reset until the image is complete.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   bus        : ioctl download stream in, cart memory port out
//   cart_size  : bytes loaded (highest written address + 1, clamped to 2^AW)
//   rom_mask   : padded span minus 1
//   size_valid : cart_size / rom_mask valid
//   overflow   : a byte at or above 2^AW was dropped
//   core_reset : reset to core and mapper, high while not IDLE
//   busy       : controller not IDLE
module cart_load_ctrl #(
   parameter int AW         = 13,
   parameter int RESET_HOLD = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   cart_load_ctrl_if.slave bus,
   output logic [AW:0]     cart_size,
   output logic [AW-1:0]   rom_mask,
   output logic            size_valid,
   output logic            overflow,
   output logic            core_reset,
   output logic            busy
);

   typedef enum logic [2:0] {IDLE, LOAD, PAD_RD, PAD_WR, HOLD} state_t;

   localparam int            CW        = $clog2(RESET_HOLD + 1);
   localparam logic [AW:0]   CAP       = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]   MIN_SPAN  = (AW >= 12) ? (AW+1)'(4096) : CAP;
   localparam logic [AW:0]   ONE_W     = (AW+1)'(1);
   localparam logic [AW-1:0] ONE_A     = AW'(1);
   localparam logic [CW-1:0] ONE_C     = CW'(1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD - 1);

   state_t        state, state_nxt;
   logic          dl_q;
   logic          rise, fall;
   logic          accept, in_range;
   logic [AW:0]   addr_p1, size_base;
   logic [AW:0]   span;
   logic [AW-1:0] span_mask;
   logic [AW-1:0] src, dst;
   logic [CW-1:0] hold_cnt;
   logic          load_we_q;
   logic [AW-1:0] load_addr_q;
   logic [7:0]    load_data_q;

   assign rise      = bus.ioctl_download & ~dl_q;
   assign fall      = ~bus.ioctl_download & dl_q;
   // A strobe on the rising-edge cycle already belongs to the new load.
   assign accept    = bus.ioctl_download & bus.ioctl_wr & (rise | (state == LOAD));
   assign in_range  = (bus.ioctl_addr[24:AW] == '0);
   assign addr_p1   = {1'b0, bus.ioctl_addr[AW-1:0]} + ONE_W;
   assign size_base = rise ? '0 : cart_size;

   // Padded span: smallest power of two >= cart_size, never below MIN_SPAN.
   // cart_size never exceeds CAP, so the doubling cannot pass it.
   always_comb begin
      span = MIN_SPAN;
      for (int i = 0; i < AW; i++) begin
         if (span < cart_size) span = span << 1;
      end
      span_mask = AW'(span - ONE_W);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= HOLD;
      else          state <= state_nxt;
   end

   always_comb begin
      // NOTE: default first so every path assigns it and no latch is inferred.
      state_nxt = state;
      if (rise) begin
         state_nxt = LOAD;
      end else begin
         case (state)
            LOAD:    if (fall) state_nxt = ((cart_size == '0) || (cart_size == span)) ? HOLD : PAD_RD;
            PAD_RD:  state_nxt = PAD_WR;
            PAD_WR:  state_nxt = (dst == rom_mask) ? HOLD : PAD_RD;
            HOLD:    if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dl_q        <= 1'b0;
         hold_cnt    <= '0;
         load_we_q   <= 1'b0;
         load_addr_q <= '0;
         load_data_q <= '0;
         src         <= '0;
         dst         <= '0;
         cart_size   <= '0;
         rom_mask    <= '1;
         size_valid  <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         dl_q      <= bus.ioctl_download;
         load_we_q <= accept & in_range;
         hold_cnt  <= (state == HOLD) ? hold_cnt + ONE_C : '0;

         if (accept && in_range) begin
            load_addr_q <= bus.ioctl_addr[AW-1:0];
            load_data_q <= bus.ioctl_dout;
         end

         if (rise) begin
            cart_size  <= '0;
            size_valid <= 1'b0;
            overflow   <= 1'b0;
         end

         if (accept) begin
            if (!in_range) begin
               overflow  <= 1'b1;
               cart_size <= CAP;
            end else if (addr_p1 > size_base) begin
               cart_size <= addr_p1;
            end
         end

         case (state)
            LOAD: begin
               if (fall) begin
                  rom_mask <= (cart_size == '0) ? '1 : span_mask;
                  src      <= '0;
                  dst      <= cart_size[AW-1:0];
               end
            end
            PAD_WR: begin
               // Source walks the loaded image and wraps, so odd sizes mirror.
               src <= ({1'b0, src} == (cart_size - ONE_W)) ? '0 : src + ONE_A;
               dst <= dst + ONE_A;
            end
            HOLD: begin
               if (!rise && (hold_cnt == HOLD_LAST)) size_valid <= (cart_size != '0);
            end
            default: ;
         endcase
      end
   end

   // Memory port decode. In PAD_WR the read issued during PAD_RD has
   // returned, so the data is forwarded straight into the write.
   always_comb begin
      busy          = (state != IDLE);
      core_reset    = (state != IDLE);
      bus.mem_we    = 1'b0;
      bus.mem_addr  = load_addr_q;
      bus.mem_wdata = load_data_q;
      case (state)
         LOAD:   bus.mem_we = load_we_q;
         PAD_RD: bus.mem_addr = src;
         PAD_WR: begin
            bus.mem_addr  = dst;
            bus.mem_wdata = bus.mem_rdata;
            bus.mem_we    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cart_load_ctrl.sv
// Self-checking bench for cart_load_ctrl.
// A byte-level model predicts every cart memory write (load stream plus
// mirrored padding) and the final image; scalar results are pinned to
// hand-computed literals.
`timescale 1ns/1ps
module tb_cart_load_ctrl;
   localparam int AW  = 13;
   localparam int RH  = 16;
   localparam int CAP = 1 << AW;

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [AW:0]   cart_size;
   logic [AW-1:0] rom_mask;
   logic          size_valid, overflow, core_reset, busy;

   cart_load_ctrl_if #(.AW(AW)) bus ();

   cart_load_ctrl #(.AW(AW), .RESET_HOLD(RH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .cart_size  (cart_size),
      .rom_mask   (rom_mask),
      .size_valid (size_valid),
      .overflow   (overflow),
      .core_reset (core_reset),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int        checks   = 0;
   int        failures = 0;
   wr_t       exp_q[$];
   logic [7:0] ram [CAP];
   logic [7:0] img [CAP];
   int        hi;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Synchronous-read cart memory.
   always @(posedge clk) begin
      if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   // Every write the DUT issues must be the next one the model predicts.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && bus.mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(bus.mem_addr), 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("mem_write", {bus.mem_addr, bus.mem_wdata}, {e.addr, e.data});
         end
      end
   end

   function automatic logic [7:0] pat(input int a, input int seed);
      return 8'((a * 7) ^ (a >> 5) ^ (seed * 37));
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input int a, input logic [7:0] d);
      wr_t e;
      e.addr = AW'(a);
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Raises download and streams bytes 0..n-1 back to back.
   task automatic load_phase(input int n, input int seed, input bit coincident);
      hi = 0;
      bus.ioctl_download = 1'b1;
      if (!coincident) begin
         bus.ioctl_wr = 1'b0;
         step();
      end
      for (int a = 0; a < n; a++) begin
         bus.ioctl_wr   = 1'b1;
         bus.ioctl_addr = 25'(a);
         bus.ioctl_dout = pat(a, seed);
         if (a < CAP) begin
            img[a] = pat(a, seed);
            push_wr(a, pat(a, seed));
            if (a + 1 > hi) hi = a + 1;
         end else begin
            hi = CAP;
         end
         step();
      end
      bus.ioctl_wr = 1'b0;
   endtask

   // Drops download; predicts the mirrored padding and the release latency.
   task automatic drop_download(output int lat);
      int p;
      bus.ioctl_download = 1'b0;
      bus.ioctl_wr       = 1'b0;
      p = 4096;
      while (p < hi) p = p * 2;
      if (p > CAP) p = CAP;
      if (hi == 0 || hi == p) begin
         lat = RH + 1;
      end else begin
         for (int a = hi; a < p; a++) begin
            img[a] = img[a % hi];
            push_wr(a, img[a]);
         end
         lat = 2 * (p - hi) + RH + 1;
      end
   endtask

   task automatic wait_fall(input int exp_lat, input string name);
      int cnt = 0;
      do begin
         step();
         cnt++;
      end while (core_reset !== 1'b0 && cnt < exp_lat + 64);
      check(name, cnt, exp_lat);
   endtask

   task automatic check_image(input int span, input string name);
      int bad = 0;
      for (int a = 0; a < span; a++) if (ram[a] !== img[a]) bad++;
      check(name, bad, 0);
   endtask

   task automatic check_results(input string tag, input int size, input int mask,
                                input bit valid, input bit ovf);
      check({tag, "_cart_size"},  cart_size,  size);
      check({tag, "_rom_mask"},   rom_mask,   mask);
      check({tag, "_size_valid"}, size_valid, valid);
      check({tag, "_overflow"},   overflow,   ovf);
      check({tag, "_busy"},       busy,       0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_core_reset"}, core_reset,    1);
      check({tag, "_busy"},       busy,          1);
      check({tag, "_mem_we"},     bus.mem_we,    0);
      check({tag, "_mem_addr"},   bus.mem_addr,  0);
      check({tag, "_mem_wdata"},  bus.mem_wdata, 0);
      check({tag, "_cart_size"},  cart_size,     0);
      check({tag, "_rom_mask"},   rom_mask,      32'h1FFF);
      check({tag, "_size_valid"}, size_valid,    0);
      check({tag, "_overflow"},   overflow,      0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;
      int bad;
      bit found;

      reset_n            = 1'b0;
      bus.ioctl_download = 1'b0;
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_addr     = '0;
      bus.ioctl_dout     = '0;

      // Power-on reset, then the hold counter releases the core.
      #12;
      check_reset_values("por");
      step();
      reset_n = 1'b1;
      wait_fall(RH, "por_release_lat");
      check_results("por", 0, 32'h1FFF, 0, 0);

      // Exactly 4 KiB: no padding.
      load_phase(4096, 1, 0);
      drop_download(lat);
      wait_fall(lat, "load4096_lat");
      check("load4096_lat_literal", lat, RH + 1);
      check_results("load4096", 4096, 32'h0FFF, 1, 0);
      check_image(4096, "load4096_image");

      // 2 KiB: upper half mirrors the lower half.
      load_phase(2048, 2, 0);
      check("load2048_core_reset_during", core_reset, 1);
      drop_download(lat);
      wait_fall(lat, "load2048_lat");
      check("load2048_lat_literal", lat, 2 * 2048 + RH + 1);
      check_results("load2048", 2048, 32'h0FFF, 1, 0);
      check_image(4096, "load2048_image");
      bad = 0;
      for (int a = 2048; a < 4096; a++) if (ram[a] !== ram[a - 2048]) bad++;
      check("load2048_mirror", bad, 0);

      // Reset mid-load while a write is on the bus; download stays high.
      load_phase(8, 5, 0);
      reset_n = 1'b0;
      void'(exp_q.pop_back());
      #1;
      check_reset_values("midload_rst");
      step();
      reset_n = 1'b1;

      // 3 KiB under the still-high download: 3072..4095 <- 0..1023.
      load_phase(3072, 3, 0);
      drop_download(lat);
      wait_fall(lat, "load3072_lat");
      check("load3072_lat_literal", lat, 2 * 1024 + RH + 1);
      check_results("load3072", 3072, 32'h0FFF, 1, 0);
      check_image(4096, "load3072_image");

      // Zero-byte download.
      load_phase(0, 4, 0);
      drop_download(lat);
      wait_fall(lat, "zero_lat");
      check_results("zero", 0, 32'h1FFF, 0, 0);

      // Oversized image: bytes at 8192 and above are dropped.
      load_phase(10000, 6, 0);
      drop_download(lat);
      wait_fall(lat, "load10000_lat");
      check_results("load10000", 8192, 32'h1FFF, 1, 1);
      check_image(8192, "load10000_image");

      // New download raised during the 10th pad write, first strobe coincident.
      load_phase(2048, 7, 0);
      drop_download(lat);
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         if (bus.mem_we === 1'b1 && bus.mem_addr === 13'd2057) found = 1'b1;
         else step();
      end
      check("abort_sync", found, 1);
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      load_phase(4096, 8, 1);
      check("abort_size_valid_during", size_valid, 0);
      check("abort_busy_during", busy, 1);
      drop_download(lat);
      wait_fall(lat, "abort_reload_lat");
      check_results("abort_reload", 4096, 32'h0FFF, 1, 0);
      check_image(4096, "abort_reload_image");

      repeat (4) step();
      check("pending_writes", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
